paralelo_serial_tx: RTL and testbench

Transmit-side parallel-to-serial stage. It feeds the serial_paralelo receiver.
- Accepts bytes on a valid/ready handshake and shifts them out MSB-first, one bit per clk_32f cycle.
- Sends the COM symbol 0xBC whenever no data is pending.
- After reset, emits a fixed number of COM symbols before accepting data, so the receiver can lock its BC counter and assert active.

---
 rtl/paralelo_serial_tx_if.sv | 39 +++
 rtl/paralelo_serial_tx.sv | 150 +++++++++++++++
 tb/tb_paralelo_serial_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// rtl/paralelo_serial_tx_if.sv - byte handshake and serial-side signals of the parallel-to-serial transmitter
//
// Purpose : groups the upstream valid/ready byte bus and the serial-side
//           outputs of paralelo_serial_tx into one bundle.
// Signals :
//   data_in    [7:0] byte to transmit                  (master -> slave)
//   valid_in         data_in is valid                  (master -> slave)
//   ready_out        holding register can take a byte  (slave  -> master)
//   data_out         serial bit, MSB first             (slave  -> master)
//   byte_start       data_out carries bit 7 of a byte  (slave  -> master)
//   active           link past sync phase              (slave  -> master)
// Modports: master = upstream byte source / observer, slave = the transmitter.

interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  byte_start,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output byte_start,
    output active
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - transmit-side parallel-to-serial stage with COM sync/idle insertion
//
// Purpose : accepts bytes on a valid/ready handshake and shifts them out
//           MSB-first, one bit per clk_32f cycle. COM_SYMBOL is sent whenever
//           no byte is pending. After reset SYNC_COMS COM bytes are sent
//           before the link goes active and data is accepted.
// Ports   :
//   clk_32f  in   bit clock, all registers rising-edge
//   reset_L  in   asynchronous active-low reset
//   bus      slave modport of paralelo_serial_tx_if
//            (data_in, valid_in, ready_out, data_out, byte_start, active)
// Parameters:
//   SYNC_COMS   COM bytes sent after reset before ACTIVE (1..15)
//   COM_SYMBOL  idle / alignment byte
//   SKIP_PERIOD data bytes between forced COMs (only with the macro below)
// Optional feature macro: PS_TX_SKIP_INSERT_EN
//   defined   -> a COM is forced after every SKIP_PERIOD back-to-back data bytes
//   undefined -> back-to-back data bytes are unlimited

module paralelo_serial_tx #(
  parameter int         SYNC_COMS  = 4,
  parameter logic [7:0] COM_SYMBOL = 8'hBC
`ifdef PS_TX_SKIP_INSERT_EN
  ,
  parameter int         SKIP_PERIOD = 16
`endif
) (
  input  logic                  clk_32f,
  input  logic                  reset_L,
  paralelo_serial_tx_if.slave   bus
);

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMS - 1);

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [0:0] state_q, state_d;

`ifdef PS_TX_SKIP_INSERT_EN
  localparam logic [7:0] SKIP_LAST = 8'(SKIP_PERIOD);
  logic [7:0] data_run_q, data_run_d;
`endif

  logic load_edge;
  logic ready;
  logic accept;

  // The edge that ends bit 0 of the current byte loads the next byte.
  assign load_edge = (bit_cnt_q == 3'd7);
  assign ready     = (state_q == ST_ACTIVE) & ~hold_full_q;
  assign accept    = bus.valid_in & ready;

  assign bus.data_out   = shift_q[7];
  assign bus.byte_start = (bit_cnt_q == 3'd0);
  assign bus.active     = (state_q == ST_ACTIVE);
  assign bus.ready_out  = ready;

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    com_cnt_d   = com_cnt_q;
    state_d     = state_q;
`ifdef PS_TX_SKIP_INSERT_EN
    data_run_d  = data_run_q;
`endif

    if (!load_edge) begin
      shift_d = {shift_q[6:0], 1'b0};
    end else begin
      // Default load is a COM; it is replaced only by pending data while active.
      shift_d = COM_SYMBOL;

      if ((state_q == ST_ACTIVE) && hold_full_q) begin
`ifdef PS_TX_SKIP_INSERT_EN
        if (data_run_q == SKIP_LAST) begin
          // Forced COM: hold_reg stays full and goes out on the next byte slot.
          data_run_d = 8'd0;
        end else begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          data_run_d  = data_run_q + 8'd1;
        end
`else
        shift_d     = hold_q;
        hold_full_d = 1'b0;
`endif
      end
`ifdef PS_TX_SKIP_INSERT_EN
      else begin
        data_run_d = 8'd0;
      end
`endif

      // Sync phase: the byte loaded on the transition edge is still a COM,
      // because the selection above looked at the pre-edge state.
      if (state_q == ST_SYNC) begin
        if (com_cnt_q == SYNC_LAST) begin
          state_d   = ST_ACTIVE;
          com_cnt_d = 4'd0;
        end else begin
          com_cnt_d = com_cnt_q + 4'd1;
        end
      end
    end

    // ready_out is low while hold_full is set, so an accept never lands on
    // the same edge as a consume and this override cannot lose a byte.
    if (accept) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shift_q     <= COM_SYMBOL;
      bit_cnt_q   <= 3'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      com_cnt_q   <= 4'd0;
      state_q     <= ST_SYNC;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      com_cnt_q   <= com_cnt_d;
      state_q     <= state_d;
    end
  end

`ifdef PS_TX_SKIP_INSERT_EN
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      data_run_q <= 8'd0;
    end else begin
      data_run_q <= data_run_d;
    end
  end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - directed self-checking bench for paralelo_serial_tx

module tb_paralelo_serial_tx;

  localparam logic [7:0] COM = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  paralelo_serial_tx_if bus();

  paralelo_serial_tx dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial monitor: rebuilds bytes off the wire, aligned on byte_start.
  logic [7:0] wire_q[$];
  logic [7:0] mon_byte = 8'd0;
  int         mon_cnt  = 0;

  always @(negedge clk_32f) begin
    if (!reset_L) begin
      mon_cnt = 0;
    end else begin
      if (bus.byte_start) begin
        mon_byte = {7'd0, bus.data_out};
        mon_cnt  = 1;
      end else begin
        mon_byte = {mon_byte[6:0], bus.data_out};
        mon_cnt  = mon_cnt + 1;
      end
      if (mon_cnt == 8) begin
        wire_q.push_back(mon_byte);
        mon_cnt = 0;
      end
    end
  end

  // One clock: sample point is just after the falling edge.
  task automatic step();
    @(negedge clk_32f);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (wire_q.size() < n && k < 500) begin
      step();
      k++;
    end
    check_eq("wait_bytes", 32'(wire_q.size() >= n), 32'd1);
  endtask

  // Offer one byte and return after the edge that takes it.
  task automatic send_byte(input logic [7:0] b);
    int k;
    bus.data_in  = b;
    bus.valid_in = 1'b1;
    k = 0;
    while (!bus.ready_out && k < 40) begin
      step();
      k++;
    end
    check_eq("send_ready", 32'(bus.ready_out), 32'd1);
    step();
  endtask

  logic [7:0] exp_q[$];
  logic       any_ready;

  initial begin
    bus.data_in  = 8'd0;
    bus.valid_in = 1'b0;

    // Reset state
    step_n(2);
    check_eq("rst_data_out",   32'(bus.data_out),   32'd1);
    check_eq("rst_byte_start", 32'(bus.byte_start), 32'd1);
    check_eq("rst_active",     32'(bus.active),     32'd0);
    check_eq("rst_ready",      32'(bus.ready_out),  32'd0);

    // 1. sync phase after release
    @(posedge clk_32f);
    #1 reset_L = 1'b1;
    step();                                   // cycle 0
    wire_q.delete();
    check_eq("t1_bs_c0", 32'(bus.byte_start), 32'd1);
    step_n(3);                                // cycle 3
    check_eq("t1_bs_c3", 32'(bus.byte_start), 32'd0);
    step_n(5);                                // cycle 8
    check_eq("t1_bs_c8", 32'(bus.byte_start), 32'd1);
    step_n(23);                               // cycle 31
    check_eq("t1_active_c31", 32'(bus.active), 32'd0);
    check_eq("t1_nbytes", 32'(wire_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("t1_com", 32'(wire_q[i]), 32'(COM));
    step();                                   // cycle 32
    check_eq("t1_active_c32", 32'(bus.active), 32'd1);
    check_eq("t1_ready_c32",  32'(bus.ready_out), 32'd1);

    // 2. single byte offered mid-byte
    wire_q.delete();
    step_n(3);                                // cycle 35, bit_cnt 3
    bus.data_in  = 8'hA5;
    bus.valid_in = 1'b1;
    check_eq("t2_ready_pre", 32'(bus.ready_out), 32'd1);
    step();                                   // accepted
    bus.valid_in = 1'b0;
    check_eq("t2_ready_held", 32'(bus.ready_out), 32'd0);
    step_n(3);                                // cycle 39, bit_cnt 7
    check_eq("t2_ready_bit7", 32'(bus.ready_out), 32'd0);
    step();                                   // cycle 40, loaded
    check_eq("t2_ready_after", 32'(bus.ready_out), 32'd1);
    wait_bytes(3);
    check_eq("t2_b0", 32'(wire_q[0]), 32'(COM));
    check_eq("t2_b1", 32'(wire_q[1]), 32'h0A5);
    check_eq("t2_b2", 32'(wire_q[2]), 32'(COM));

    // 3. streaming 01 02 03
    wire_q.delete();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    bus.valid_in = 1'b0;
    wait_bytes(5);
    check_eq("t3_b0", 32'(wire_q[0]), 32'(COM));
    check_eq("t3_b1", 32'(wire_q[1]), 32'h01);
    check_eq("t3_b2", 32'(wire_q[2]), 32'h02);
    check_eq("t3_b3", 32'(wire_q[3]), 32'h03);
    check_eq("t3_b4", 32'(wire_q[4]), 32'(COM));

    // 4. reset in the middle of 0x3C
    send_byte(8'h3C);
    bus.valid_in = 1'b0;
    begin
      int k;
      k = 0;
      while (!bus.ready_out && k < 40) begin
        step();
        k++;
      end
    end
    check_eq("t4_bs_start", 32'(bus.byte_start), 32'd1);
    check_eq("t4_bit7",     32'(bus.data_out),   32'd0);
    step();
    check_eq("t4_bit6",     32'(bus.data_out),   32'd0);
    step_n(3);                                // bit_cnt 4
    check_eq("t4_bit3",     32'(bus.data_out),   32'd1);
    check_eq("t4_active",   32'(bus.active),     32'd1);
    reset_L = 1'b0;
    #1;
    check_eq("t4_rst_data",   32'(bus.data_out),   32'd1);
    check_eq("t4_rst_active", 32'(bus.active),     32'd0);
    check_eq("t4_rst_ready",  32'(bus.ready_out),  32'd0);
    check_eq("t4_rst_bs",     32'(bus.byte_start), 32'd1);

    // 5. valid during sync, accepted on first active edge
    bus.data_in  = 8'h77;
    bus.valid_in = 1'b1;
    @(posedge clk_32f);
    #1 reset_L = 1'b1;
    step();                                   // cycle 0
    wire_q.delete();
    any_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.ready_out) any_ready = 1'b1;
      step();
    end                                       // cycle 32
    check_eq("t5_no_ready_sync", 32'(any_ready), 32'd0);
    check_eq("t5_active",        32'(bus.active), 32'd1);
    check_eq("t5_ready",         32'(bus.ready_out), 32'd1);
    step();
    bus.valid_in = 1'b0;
    check_eq("t5_taken", 32'(bus.ready_out), 32'd0);
    wait_bytes(7);
    for (int i = 0; i < 5; i++)
      check_eq("t5_com", 32'(wire_q[i]), 32'(COM));
    check_eq("t5_data", 32'(wire_q[5]), 32'h77);
    check_eq("t5_tail", 32'(wire_q[6]), 32'(COM));

    // 6. long stream 0x00..0x14
    wire_q.delete();
    exp_q.delete();
    exp_q.push_back(COM);
    for (int i = 0; i <= 8'h14; i++) begin
`ifdef PS_TX_SKIP_INSERT_EN
      if (i == 16) exp_q.push_back(COM);
`endif
      exp_q.push_back(8'(i));
    end
    exp_q.push_back(COM);
    for (int i = 0; i <= 8'h14; i++)
      send_byte(8'(i));
    bus.valid_in = 1'b0;
    wait_bytes(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("t6_b%0d", i), 32'(wire_q[i]), 32'(exp_q[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
